// File: rtl/sps_pkg.sv
// Shared constants and helpers for the smart parking controller:
// slot geometry, seven-segment codes and display reset values.
package sps_pkg;

    localparam int N_SLOTS  = 4;
    localparam int SLOT_W   = $clog2(N_SLOTS);
    localparam int N_DIGITS = 5;

    typedef logic [N_SLOTS-1:0] slot_mask_t;

    // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}; dp stays off.
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [N_DIGITS-1:0] SEG_SEL_RST  = 5'b11110;
    localparam logic [7:0]          SEG_DATA_RST = SEG_0;

    function automatic logic [7:0] seg_code(input logic [2:0] value);
        case (value)
            3'd0:    return SEG_0;
            3'd1:    return SEG_1;
            3'd2:    return SEG_2;
            3'd3:    return SEG_3;
            3'd4:    return SEG_4;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/sps_debounce.sv
// Button conditioner: 2-flop synchroniser, stability-count debouncer and a
// one-cycle pulse on each debounced 0->1 transition.
module sps_debounce #(
    parameter int COUNT_VALUE = 400000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CW = $clog2(COUNT_VALUE + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          level_d_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop in this block samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
            rise      <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], raw};
            level_d_q <= level_q;
            rise      <= level_q & ~level_d_q;
            // Any cycle where the input agrees with the level restarts the count.
            if (sync_q[1] != level_q) begin
                if (cnt_q == CW'(COUNT_VALUE - 1)) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/smart_parking_controller.sv
// Four-slot car park controller: debounced entry/exit events, slot
// occupancy, door timer, full indicator and a 5-digit multiplexed display.
module smart_parking_controller
    import sps_pkg::*;
#(
    parameter int COUNT_VALUE = 400000,
    parameter int DOOR_CYCLES = 80000000,
    parameter int SCAN_CYCLES = 40000
) (
    input  logic                clk,
    input  logic                reset_in,
    input  logic                entry_signal_in,
    input  logic                exit_signal_in,
    input  logic [SLOT_W-1:0]   exit_slot_in,
    output logic [N_DIGITS-1:0] SEG_SEL,
    output logic [7:0]          SEG_DATA,
    output logic [N_SLOTS-1:0]  spots,
    output logic                doorLED,
    output logic                fullLED
);

    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam int SW = $clog2(SCAN_CYCLES + 1);

    logic          entry_evt;
    logic          exit_evt;
    logic          entry_ok;
    logic          exit_ok;
    logic          found;
    slot_mask_t    alloc_mask;
    slot_mask_t    exit_mask;
    slot_mask_t    spots_next;
    logic [DW-1:0] door_q;
    logic [SW-1:0] scan_q;
    logic [2:0]    digit_q;
    logic [2:0]    free_cnt;
    logic [N_DIGITS-1:0] sel_next;
    logic [7:0]          data_next;

    sps_debounce #(.COUNT_VALUE(COUNT_VALUE)) u_entry_db (
        .clk  (clk),
        .rst  (reset_in),
        .raw  (entry_signal_in),
        .rise (entry_evt)
    );

    sps_debounce #(.COUNT_VALUE(COUNT_VALUE)) u_exit_db (
        .clk  (clk),
        .rst  (reset_in),
        .raw  (exit_signal_in),
        .rise (exit_evt)
    );

    // Entry and exit both judge the pre-event occupancy, so an entry can
    // never claim a slot freed in the same cycle and a full park rejects it.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        alloc_mask = '0;
        exit_mask  = '0;
        found      = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!found && !spots[i]) begin
                alloc_mask[i] = 1'b1;
                found         = 1'b1;
            end
        end
        entry_ok = entry_evt && (spots != '1);
        exit_ok  = exit_evt && spots[exit_slot_in];
        if (exit_ok) begin
            exit_mask[exit_slot_in] = 1'b1;
        end
        spots_next = (spots & ~exit_mask) | (entry_ok ? alloc_mask : '0);
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            spots   <= '0;
            fullLED <= 1'b0;
            door_q  <= '0;
        end else begin
            spots   <= spots_next;
            fullLED <= &spots_next;
            if (entry_ok || exit_ok) begin
                door_q <= DW'(DOOR_CYCLES);
            end else if (door_q != '0) begin
                door_q <= door_q - 1'b1;
            end
        end
    end

    assign doorLED = (door_q != '0);

    always_comb begin
        free_cnt = 3'(N_SLOTS);
        for (int i = 0; i < N_SLOTS; i++) begin
            if (spots[i]) begin
                free_cnt = free_cnt - 3'd1;
            end
        end
        sel_next = ~(N_DIGITS'(1) << digit_q);
        if (digit_q == 3'(N_DIGITS - 1)) begin
            data_next = seg_code(free_cnt);
        end else begin
            data_next = spots[digit_q[SLOT_W-1:0]] ? SEG_1 : SEG_0;
        end
    end

    // Select and segment data are registered together so digits never ghost.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            scan_q   <= '0;
            digit_q  <= '0;
            SEG_SEL  <= SEG_SEL_RST;
            SEG_DATA <= SEG_DATA_RST;
        end else begin
            SEG_SEL  <= sel_next;
            SEG_DATA <= data_next;
            if (scan_q == SW'(SCAN_CYCLES - 1)) begin
                scan_q  <= '0;
                digit_q <= (digit_q == 3'(N_DIGITS - 1)) ? 3'd0 : digit_q + 3'd1;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_smart_parking_controller.sv
// Directed self-checking bench for smart_parking_controller with
// COUNT_VALUE=2, DOOR_CYCLES=8, SCAN_CYCLES=4.
module tb_smart_parking_controller;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       entry_signal_in;
    logic       exit_signal_in;
    logic [1:0] exit_slot_in;
    logic [4:0] SEG_SEL;
    logic [7:0] SEG_DATA;
    logic [3:0] spots;
    logic       doorLED;
    logic       fullLED;

    int n_cmp = 0;
    int n_err = 0;

    smart_parking_controller #(
        .COUNT_VALUE (2),
        .DOOR_CYCLES (8),
        .SCAN_CYCLES (4)
    ) dut (
        .clk             (clk),
        .reset_in        (reset_in),
        .entry_signal_in (entry_signal_in),
        .exit_signal_in  (exit_signal_in),
        .exit_slot_in    (exit_slot_in),
        .SEG_SEL         (SEG_SEL),
        .SEG_DATA        (SEG_DATA),
        .spots           (spots),
        .doorLED         (doorLED),
        .fullLED         (fullLED)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sel(input logic [4:0] sel, input string tag);
        int n = 0;
        while (SEG_SEL !== sel && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_sel"}, 32'(SEG_SEL), 32'(sel));
    endtask

    // Raise the chosen buttons for 4 cycles; returns on the cycle the
    // resulting event has just updated spots (6 cycles after the press).
    task automatic pulse(input logic en, input logic ex, input logic [1:0] slot);
        exit_slot_in    = slot;
        entry_signal_in = en;
        exit_signal_in  = ex;
        tick(4);
        entry_signal_in = 1'b0;
        exit_signal_in  = 1'b0;
        tick(2);
    endtask

    initial begin
        int hold;
        reset_in        = 1'b1;
        entry_signal_in = 1'b0;
        exit_signal_in  = 1'b0;
        exit_slot_in    = 2'd0;
        tick(12);
        check("rst_spots", 32'(spots), 32'h0);
        check("rst_door", 32'(doorLED), 32'h0);
        check("rst_full", 32'(fullLED), 32'h0);
        check("rst_sel", 32'(SEG_SEL), 32'h1E);
        check("rst_data", 32'(SEG_DATA), 32'hC0);
        reset_in = 1'b0;

        wait_sel(5'b11101, "scan_d1");
        check("scan_d1_data", 32'(SEG_DATA), 32'hC0);
        wait_sel(5'b11011, "scan_d2");
        check("scan_d2_data", 32'(SEG_DATA), 32'hC0);
        wait_sel(5'b10111, "scan_d3");
        check("scan_d3_data", 32'(SEG_DATA), 32'hC0);
        wait_sel(5'b01111, "scan_d4");
        check("scan_d4_free4", 32'(SEG_DATA), 32'h99);
        hold = 0;
        while (SEG_SEL === 5'b01111 && hold < 20) begin
            tick(1);
            hold++;
        end
        check("scan_hold", 32'(hold), 32'd4);
        wait_sel(5'b11110, "scan_wrap");
        check("scan_wrap_data", 32'(SEG_DATA), 32'hC0);

        // Single entry held 8 cycles.
        entry_signal_in = 1'b1;
        tick(5);
        check("entry_latency", 32'(spots), 32'h0);
        tick(1);
        check("entry_spots", 32'(spots), 32'h1);
        check("entry_door", 32'(doorLED), 32'h1);
        check("entry_full", 32'(fullLED), 32'h0);
        tick(2);
        entry_signal_in = 1'b0;
        tick(5);
        check("door_last_cycle", 32'(doorLED), 32'h1);
        tick(1);
        check("door_expired", 32'(doorLED), 32'h0);
        wait_sel(5'b11110, "entry_d0");
        check("entry_d0_data", 32'(SEG_DATA), 32'hF9);
        wait_sel(5'b01111, "entry_d4");
        check("entry_d4_free3", 32'(SEG_DATA), 32'hB0);

        pulse(1'b0, 1'b1, 2'd0);
        check("exit0_spots", 32'(spots), 32'h0);
        check("exit0_door", 32'(doorLED), 32'h1);
        tick(10);
        check("exit0_door_off", 32'(doorLED), 32'h0);
        pulse(1'b0, 1'b1, 2'd2);
        check("exit_empty_spots", 32'(spots), 32'h0);
        check("exit_empty_door", 32'(doorLED), 32'h0);
        tick(2);

        // Bounce: toggling every cycle never settles long enough.
        for (int i = 0; i < 10; i++) begin
            entry_signal_in = ~entry_signal_in;
            tick(1);
        end
        tick(12);
        check("bounce_spots", 32'(spots), 32'h0);
        check("bounce_door", 32'(doorLED), 32'h0);
        entry_signal_in = 1'b1;
        tick(1);
        entry_signal_in = 1'b0;
        tick(12);
        check("glitch_spots", 32'(spots), 32'h0);

        pulse(1'b1, 1'b0, 2'd0);
        check("fill1", 32'(spots), 32'h1);
        tick(2);
        pulse(1'b1, 1'b0, 2'd0);
        check("fill2", 32'(spots), 32'h3);
        check("door_retrigger", 32'(doorLED), 32'h1);
        tick(2);
        pulse(1'b1, 1'b0, 2'd0);
        check("fill3", 32'(spots), 32'h7);
        check("fill3_full", 32'(fullLED), 32'h0);
        tick(2);
        pulse(1'b1, 1'b0, 2'd0);
        check("fill4", 32'(spots), 32'hF);
        check("fill4_full", 32'(fullLED), 32'h1);
        tick(10);
        check("fill_door_off", 32'(doorLED), 32'h0);
        wait_sel(5'b01111, "full_d4");
        check("full_d4_free0", 32'(SEG_DATA), 32'hC0);
        wait_sel(5'b11110, "full_d0");
        check("full_d0_data", 32'(SEG_DATA), 32'hF9);
        pulse(1'b1, 1'b0, 2'd0);
        check("reject_spots", 32'(spots), 32'hF);
        check("reject_door", 32'(doorLED), 32'h0);
        check("reject_full", 32'(fullLED), 32'h1);
        tick(2);

        // Simultaneous entry and exit on a full park.
        pulse(1'b1, 1'b1, 2'd1);
        check("simul_spots", 32'(spots), 32'hD);
        check("simul_full", 32'(fullLED), 32'h0);
        check("simul_door", 32'(doorLED), 32'h1);
        tick(2);
        wait_sel(5'b01111, "simul_d4");
        check("simul_d4_free1", 32'(SEG_DATA), 32'hF9);
        wait_sel(5'b11101, "simul_d1");
        check("simul_d1_data", 32'(SEG_DATA), 32'hC0);
        pulse(1'b1, 1'b0, 2'd0);
        check("refill_spots", 32'(spots), 32'hF);
        tick(3);
        check("mid_door", 32'(doorLED), 32'h1);

        // Asynchronous reset while the door timer runs.
        #2 reset_in = 1'b1;
        #1;
        check("async_door", 32'(doorLED), 32'h0);
        check("async_spots", 32'(spots), 32'h0);
        check("async_full", 32'(fullLED), 32'h0);
        check("async_sel", 32'(SEG_SEL), 32'h1E);
        check("async_data", 32'(SEG_DATA), 32'hC0);
        tick(2);
        reset_in = 1'b0;
        tick(3);
        check("post_rst_spots", 32'(spots), 32'h0);
        check("post_rst_door", 32'(doorLED), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/smart_parking_controller.md
Name: smart_parking_controller

Overview:
- Top-level controller for a 4-slot car park on a 40 MHz FPGA board.
- Debounces the entry and exit buttons, then tracks slot occupancy.
- Drives slot LEDs, a door LED and a full LED, plus a 5-digit multiplexed seven-segment display.

Parameters:
- COUNT_VALUE, default 400000: clock cycles an input must remain stable before the debounced value updates (10 ms at 40 MHz). Benches set it to 2.
- DOOR_CYCLES, default 80000000: cycles doorLED stays lit after an accepted event (2 s).
- SCAN_CYCLES, default 40000: cycles each display digit is held (1 ms).

Ports:
- clk  in  1  system clock, 40 MHz.
- reset_in  in  1  asynchronous, active-high reset.
- entry_signal_in  in  1  raw entry button, unsynchronised.
- exit_signal_in  in  1  raw exit button, unsynchronised.
- exit_slot_in  in  2  slot index (0-3) being vacated, sampled when an exit event fires.
- SEG_SEL  out  5  digit enables, active-low one-hot.
- SEG_DATA  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- spots  out  4  bit i high = slot i occupied.
- doorLED  out  1  door-open indicator.
- fullLED  out  1  high when all 4 slots are occupied.

Behaviour:
- Reset values: spots=0, doorLED=0, fullLED=0, SEG_SEL=5'b11110, SEG_DATA=8'hC0. All counters and debouncer states clear; debounced button values clear to 0.
- Input conditioning: each button passes through a 2-flop synchroniser, then a debouncer.
  - The debounced value takes the synchronised value after it has been stable for COUNT_VALUE consecutive cycles.
  - An event is a single-cycle pulse on the debounced 0->1 edge, which is button release for the board's active-low switches.
  - Holding a level never repeats the event.
- Entry event:
  - If spots != 4'hF, set the lowest-index 0 bit of spots on the next clock and start the door timer.
  - If spots == 4'hF, ignore the event; no door opening.
- Exit event:
  - If spots[exit_slot_in] == 1, clear that bit and start the door timer.
  - If the slot is already empty, ignore the event.
- Simultaneous entry and exit events in one cycle: both evaluate against the pre-event spots value.
  - The exit clear and the entry allocation apply together.
  - Entry never takes the slot being freed in the same cycle; if the park was full, the entry is rejected.
- Door timer: loads DOOR_CYCLES on any accepted event, including re-triggering while running.
  - doorLED = (timer != 0); the timer decrements each cycle.
- fullLED = &spots. It is registered, so it updates in the same cycle as spots.
- Display: a free-running scan counter advances the digit index 0->1->2->3->4->0 every SCAN_CYCLES cycles.
  - Digit index i drives SEG_SEL bit i low and all other bits high.
  - Digits 0-3 show '1' when spots[i] is set, else '0'.
  - Digit 4 shows the free-slot count, 0-4, as a decimal digit.
  - Active-low codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99. dp is always off (bit7=1).
  - SEG_SEL and SEG_DATA are registered and change together.
- Reset mid-operation: asynchronous. All state clears immediately, including pending door time and partially debounced inputs.
- Latency:
  - Raw input change to event pulse: 2 sync cycles + COUNT_VALUE cycles + 1.
  - Event to spots/fullLED/doorLED update: 1 cycle.

Decomposition:
- Shared package sps_pkg holds:
  - N_SLOTS=4 and the slot index width.
  - Active-low seven-segment constants for digits 0-4.
  - Reset value constants for SEG_SEL and SEG_DATA.
- One sub-module, sps_debounce: synchroniser, stability counter, debounced level and rising-edge pulse output, parameterised by COUNT_VALUE. It is instantiated twice.
- Slot logic, door timer and display scan stay in the top module.

Test Plan (COUNT_VALUE=2, DOOR_CYCLES=8, SCAN_CYCLES=4):
- Reset: assert reset_in 300 ns, release -> spots=0, doorLED=0, fullLED=0, SEG_SEL=11110, SEG_DATA=C0. Scan then walks all 5 digits, with digit 4 showing 99 ('4').
- Single entry: entry pulse 200 ns -> spots=0001, doorLED high for 8 cycles, digit 0 shows F9, digit 4 shows B0 ('3').
- Exit: after entry, exit_slot_in=0 with exit pulse 100 ns -> spots=0000, doorLED retriggers. Exit with exit_slot_in=2 on an empty slot -> no change, doorLED stays low.
- Fill and reject: 4 entries -> spots=1111, fullLED=1, digit 4 shows C0. A 5th entry -> spots unchanged, doorLED not retriggered after the timer has expired.
- Bounce: entry toggled every cycle for 10 cycles, then held low -> no allocation. A pulse shorter than 2 stable cycles -> ignored.
- Simultaneous: spots=1111, entry and exit(slot 1) debounced on the same cycle -> spots=1101, fullLED=0. Reset asserted mid-door-timer -> doorLED=0 immediately.
